// File: rtl/instr_assembler_pkg.sv
// Shared definitions for the RV32I instruction assembler: format codes,
// opcodes, the canonical NOP, FSM state codes, per-format field encoders and
// the optional immediate range check used when INSTR_ASM_RANGE_CHECK_EN is set.
package instr_assembler_pkg;

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_J  = 3'd5;
  localparam logic [2:0] FMT_LI = 3'd6;

  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_LI_LO = 2'd2;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } instr_req_t;

  function automatic logic [31:0] encode_r(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encode_i(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encode_s(input logic [11:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  // Branch offsets are even, so bit 0 is never encoded.
  function automatic logic [31:0] encode_b(input logic [12:1] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  function automatic logic [31:0] encode_u(input logic [19:0] imm_hi, input logic [4:0] rd,
                                           input logic [6:0] op);
    return {imm_hi, rd, op};
  endfunction

  function automatic logic [31:0] encode_j(input logic [20:1] imm, input logic [4:0] rd,
                                           input logic [6:0] op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

  // True when the immediate cannot be represented exactly by the format.
  function automatic logic imm_out_of_range(input logic [2:0] fmt, input logic [31:0] imm);
    logic signed [31:0] s;
    logic bad;
    s   = $signed(imm);
    bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: bad = (s < -32'sd2048) || (s > 32'sd2047);
      FMT_B:        bad = (s < -32'sd4096) || (s > 32'sd4094) || imm[0];
      FMT_J:        bad = (s < -32'sd1048576) || (s > 32'sd1048574) || imm[0];
      FMT_U:        bad = (imm[11:0] != 12'd0);
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/instr_assembler_if.sv
// Request/response bundle between the boot sequencer (master) and the
// instruction assembler (slave); both directions use valid/ready.
interface instr_assembler_if;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err;

  modport master (
    output req_valid, req_fmt, req_opcode, req_funct3, req_funct7,
           req_rd, req_rs1, req_rs2, req_imm, out_ready,
    input  req_ready, out_valid, out_instr, out_last, err
  );

  modport slave (
    input  req_valid, req_fmt, req_opcode, req_funct3, req_funct7,
           req_rd, req_rs1, req_rs2, req_imm, out_ready,
    output req_ready, out_valid, out_instr, out_last, err
  );

endinterface

// File: rtl/instr_assembler_field_packer.sv
// Combinational field packer: format + fields -> 32-bit RV32I word.
// Out-of-range immediate bits are dropped by the encoders. FMT_LI and unknown
// formats yield NOP; the LI expansion lives in the top level.
module instr_field_packer
  import instr_assembler_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_instr
);

  // Bit 0 of B/J offsets is implied zero and never encoded.
  logic w_unused_imm0;
  assign w_unused_imm0 = i_imm[0];

  // Select the encoder for the requested format.
  always_comb begin
    o_instr = INSTR_NOP;
    case (i_fmt)
      FMT_R:   o_instr = encode_r(i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode);
      FMT_I:   o_instr = encode_i(i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode);
      FMT_S:   o_instr = encode_s(i_imm[11:0], i_rs2, i_rs1, i_funct3, i_opcode);
      FMT_B:   o_instr = encode_b(i_imm[12:1], i_rs2, i_rs1, i_funct3, i_opcode);
      FMT_U:   o_instr = encode_u(i_imm[31:12], i_rd, i_opcode);
      FMT_J:   o_instr = encode_j(i_imm[20:1], i_rd, i_opcode);
      default: o_instr = INSTR_NOP;
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// RV32I instruction assembler: packs request fields into words and expands
// LI into LUI+ADDI (or a single ADDI/LUI). One registered output word.
// Optional feature macro: INSTR_ASM_RANGE_CHECK_EN (immediate range check,
// rejected requests produce a one-cycle err pulse and no word). Without it
// err is constant 0 and out-of-range bits are truncated.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no word held; ready for a request
// ST_HOLD  | word registered, waiting for out_ready
// ST_LI_LO | LUI handed off, ADDI of the same LI held; requests blocked
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit LI_ALWAYS_2 = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  instr_assembler_if.slave bus
);

  logic [1:0]      r_state;
  logic            r_out_valid;
  logic [31:0]     r_instr;
  logic            r_last;
  logic [31:0]     r_lo_word;
  logic            r_err;

  logic [XLEN-1:0] w_imm;
  logic [31:0]     w_packed;
  logic [19:0]     w_li_hi;
  logic [11:0]     w_li_lo;
  logic            w_li_single_addi;
  logic            w_li_two;
  logic [31:0]     w_li_first;
  logic [31:0]     w_li_second;
  logic [31:0]     w_first_word;
  logic            w_first_last;
  logic            w_accept;
  logic            w_range_err;

  assign w_imm = bus.req_imm;

  instr_field_packer u_packer (
    .i_fmt    (bus.req_fmt),
    .i_opcode (bus.req_opcode),
    .i_funct3 (bus.req_funct3),
    .i_funct7 (bus.req_funct7),
    .i_rd     (bus.req_rd),
    .i_rs1    (bus.req_rs1),
    .i_rs2    (bus.req_rs2),
    .i_imm    (w_imm),
    .o_instr  (w_packed)
  );

  // (imm + 0x800) >> 12 is the upper 20 bits plus the carry out of the low 12,
  // which is just imm[11]; this compensates ADDI's sign extension of lo.
  assign w_li_hi = w_imm[31:12] + {19'd0, w_imm[11]};
  assign w_li_lo = w_imm[11:0];

  assign w_li_single_addi = !LI_ALWAYS_2 && (w_li_hi == 20'd0);
  assign w_li_two         = LI_ALWAYS_2 || ((w_li_hi != 20'd0) && (w_li_lo != 12'd0));

  assign w_li_first  = w_li_single_addi
                     ? encode_i(w_li_lo, 5'd0, 3'd0, bus.req_rd, OPCODE_OP_IMM)
                     : encode_u(w_li_hi, bus.req_rd, OPCODE_LUI);
  assign w_li_second = encode_i(w_li_lo, bus.req_rd, 3'd0, bus.req_rd, OPCODE_OP_IMM);

  assign w_first_word = (bus.req_fmt == FMT_LI) ? w_li_first : w_packed;
  assign w_first_last = (bus.req_fmt == FMT_LI) ? !w_li_two : 1'b1;

`ifdef INSTR_ASM_RANGE_CHECK_EN
  assign w_range_err = imm_out_of_range(bus.req_fmt, bus.req_imm);
`else
  assign w_range_err = 1'b0;
`endif

  // A new request may be taken while the final word of the previous one leaves.
  assign bus.req_ready = (r_state == ST_IDLE) ||
                         ((r_state == ST_HOLD) && bus.out_ready && r_last);
  assign w_accept      = bus.req_valid && bus.req_ready;

  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_instr;
  assign bus.out_last  = r_last;
  assign bus.err       = r_err;

  // Sequencer: output handoff first, then a same-cycle accept overrides it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_instr     <= 32'd0;
      r_last      <= 1'b0;
      r_lo_word   <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            if (r_last) begin
              r_out_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_instr <= r_lo_word;
              r_last  <= 1'b1;
              r_state <= ST_LI_LO;
            end
          end
        end
        ST_LI_LO: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase

      if (w_accept) begin
        if (w_range_err) begin
          r_err <= 1'b1;
        end else begin
          r_instr     <= w_first_word;
          r_last      <= w_first_last;
          r_lo_word   <= w_li_second;
          r_out_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// Self-checking bench for instr_assembler: a queue-based model of the words
// each accepted request must produce, checked every cycle, plus directed
// literal expectations.
module tb_instr_assembler;
  import instr_assembler_pkg::*;

`ifdef INSTR_ASM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam bit LI2 = 1'b0;

  typedef struct {
    bit [2:0]  fmt;
    bit [6:0]  op;
    bit [2:0]  f3;
    bit [6:0]  f7;
    bit [4:0]  rd;
    bit [4:0]  rs1;
    bit [4:0]  rs2;
    bit [31:0] imm;
  } tb_req_t;

  typedef struct {
    bit [31:0] w;
    bit        last;
    bit        second;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_assembler_if bus();

  instr_assembler #(.XLEN(32), .LI_ALWAYS_2(LI2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  bit   err_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns -1 for a rejected request, else the number of words produced.
  function automatic int model(input tb_req_t r, output bit [31:0] w0, output bit [31:0] w1);
    bit [31:0] imm, d, o, rsf, hi, lo;
    int        s;
    imm = r.imm;
    s   = $signed(r.imm);
    d   = 32'(r.rd) << 7;
    o   = 32'(r.op);
    rsf = (32'(r.rs1) << 15) | (32'(r.f3) << 12);
    w0  = 32'd0;
    w1  = 32'd0;
    if (RC) begin
      if ((r.fmt == FMT_I || r.fmt == FMT_S) && (s < -2048 || s > 2047)) return -1;
      if (r.fmt == FMT_B && (s < -4096 || s > 4094 || (imm % 2) != 0)) return -1;
      if (r.fmt == FMT_J && (s < -1048576 || s > 1048574 || (imm % 2) != 0)) return -1;
      if (r.fmt == FMT_U && (imm % 4096) != 0) return -1;
    end
    case (r.fmt)
      FMT_R: w0 = (32'(r.f7) << 25) | (32'(r.rs2) << 20) | rsf | d | o;
      FMT_I: w0 = ((imm & 32'hFFF) << 20) | rsf | d | o;
      FMT_S: w0 = (((imm >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | rsf
                | ((imm & 32'h1F) << 7) | o;
      FMT_B: w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                | (32'(r.rs2) << 20) | rsf | (((imm >> 1) & 32'hF) << 8)
                | (((imm >> 11) & 1) << 7) | o;
      FMT_U: w0 = (imm & 32'hFFFF_F000) | d | o;
      FMT_J: w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | o;
      FMT_LI: begin
        hi = (imm + 32'h800) >> 12;
        lo = imm & 32'hFFF;
        w1 = (lo << 20) | (32'(r.rd) << 15) | d | 32'h13;
        if (!LI2 && hi == 0) begin
          w0 = (lo << 20) | d | 32'h13;
          return 1;
        end
        w0 = (hi << 12) | d | 32'h37;
        if (!LI2 && lo == 0) return 1;
        return 2;
      end
      default: w0 = 32'h0000_0013;
    endcase
    return 1;
  endfunction

  // Every-cycle compare against the model; sampled on the falling edge.
  always @(negedge clk) begin : mon
    bit        exp_ready;
    bit [31:0] w0, w1;
    int        n;
    tb_req_t   r;
    if (rst) begin
      q.delete();
      err_pend = 1'b0;
    end else begin
      exp_ready = (q.size() == 0) || (q.size() == 1 && bus.out_ready && !q[0].second);
      chk("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_ready});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
      chk("err", {31'd0, bus.err}, {31'd0, err_pend});
      err_pend = 1'b0;
      if (bus.out_valid && q.size() != 0) begin
        chk("out_instr", bus.out_instr, q[0].w);
        chk("out_last", {31'd0, bus.out_last}, {31'd0, q[0].last});
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.req_valid && bus.req_ready) begin
        r = '{bus.req_fmt, bus.req_opcode, bus.req_funct3, bus.req_funct7,
              bus.req_rd, bus.req_rs1, bus.req_rs2, bus.req_imm};
        n = model(r, w0, w1);
        if (n < 0) begin
          err_pend = 1'b1;
        end else begin
          q.push_back('{w0, n == 1, 1'b0});
          if (n == 2) q.push_back('{w1, 1'b1, 1'b1});
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_fmt    = 3'd0;
    bus.req_opcode = 7'd0;
    bus.req_funct3 = 3'd0;
    bus.req_funct7 = 7'd0;
    bus.req_rd     = 5'd0;
    bus.req_rs1    = 5'd0;
    bus.req_rs2    = 5'd0;
    bus.req_imm    = 32'd0;
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input tb_req_t r);
    int k;
    bus.req_valid  = 1'b1;
    bus.req_fmt    = r.fmt;
    bus.req_opcode = r.op;
    bus.req_funct3 = r.f3;
    bus.req_funct7 = r.f7;
    bus.req_rd     = r.rd;
    bus.req_rs1    = r.rs1;
    bus.req_rs2    = r.rs2;
    bus.req_imm    = r.imm;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.req_ready) break;
    end
    if (k == 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: req_ready 0 for %0d cycles, required 1", k);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam tb_req_t REQ_I    = '{FMT_I, 7'h13, 3'd0, 7'd0, 5'd3, 5'd2, 5'd0, 32'd4};
  localparam tb_req_t REQ_B    = '{FMT_B, 7'h63, 3'd5, 7'd0, 5'd0, 5'd3, 5'd4, 32'd12};
  localparam tb_req_t REQ_J    = '{FMT_J, 7'h6F, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd80};
  localparam tb_req_t REQ_LI2  = '{FMT_LI, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF};
  localparam tb_req_t REQ_LI1  = '{FMT_LI, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h0000_07FF};
  localparam tb_req_t REQ_B13  = '{FMT_B, 7'h63, 3'd5, 7'd0, 5'd0, 5'd3, 5'd4, 32'd13};

  tb_req_t   burst[9];
  bit [31:0] mw0, mw1;
  int        mn;

  initial begin
    burst[0] = '{FMT_R,  7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0};
    burst[1] = '{FMT_S,  7'h23, 3'd2, 7'd0,  5'd0, 5'd2, 5'd5, 32'hFFFF_FFF8};
    burst[2] = '{FMT_U,  7'h37, 3'd0, 7'd0,  5'd7, 5'd0, 5'd0, 32'hABCD_E000};
    burst[3] = '{3'd7,   7'h33, 3'd1, 7'd1,  5'd9, 5'd9, 5'd9, 32'h1234_5678};
    burst[4] = '{FMT_LI, 7'd0,  3'd0, 7'd0,  5'd6, 5'd0, 5'd0, 32'h1234_5000};
    burst[5] = '{FMT_LI, 7'd0,  3'd0, 7'd0,  5'd7, 5'd0, 5'd0, 32'hFFFF_FFFF};
    burst[6] = '{FMT_LI, 7'd0,  3'd0, 7'd0,  5'd8, 5'd0, 5'd0, 32'h0000_0800};
    burst[7] = '{FMT_LI, 7'd0,  3'd0, 7'd0,  5'd0, 5'd0, 5'd0, 32'h8000_0000};
    burst[8] = '{FMT_I,  7'h13, 3'd0, 7'd0,  5'd4, 5'd4, 5'd0, 32'hFFFF_FFFF};

    // Pin the model to hand-computed encodings.
    mn = model(REQ_I, mw0, mw1);
    chk("model_I", mw0, 32'h0041_0193);
    mn = model(REQ_B, mw0, mw1);
    chk("model_B", mw0, 32'h0041_D663);
    mn = model(REQ_J, mw0, mw1);
    chk("model_J", mw0, 32'h0500_01EF);
    mn = model(REQ_LI2, mw0, mw1);
    chk("model_LI2_n", mn, 32'd2);
    chk("model_LI2_hi", mw0, 32'h1234_62B7);
    chk("model_LI2_lo", mw1, 32'hFFF2_8293);
    mn = model(REQ_LI1, mw0, mw1);
    chk("model_LI1_n", mn, 32'd1);
    chk("model_LI1", mw0, 32'h7FF0_0293);

    idle_inputs();
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    step();

    send(REQ_I);
    @(negedge clk);
    chk("I_word", bus.out_instr, 32'h0041_0193);
    chk("I_last", {31'd0, bus.out_last}, 32'd1);
    step();

    send(REQ_B);
    @(negedge clk);
    chk("B_word", bus.out_instr, 32'h0041_D663);
    step();

    send(REQ_J);
    @(negedge clk);
    chk("J_word", bus.out_instr, 32'h0500_01EF);
    step();

    send(REQ_LI2);
    @(negedge clk);
    chk("LI_hi_word", bus.out_instr, 32'h1234_62B7);
    chk("LI_hi_last", {31'd0, bus.out_last}, 32'd0);
    step();
    @(negedge clk);
    chk("LI_lo_word", bus.out_instr, 32'hFFF2_8293);
    chk("LI_lo_last", {31'd0, bus.out_last}, 32'd1);
    step();

    send(REQ_LI1);
    @(negedge clk);
    chk("LI1_word", bus.out_instr, 32'h7FF0_0293);
    chk("LI1_last", {31'd0, bus.out_last}, 32'd1);
    step();

    for (int i = 0; i < 9; i++) send(burst[i]);
    repeat (4) step();

    // Backpressure during LI: LUI held, requests blocked.
    bus.out_ready = 1'b0;
    send(REQ_LI2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_word", bus.out_instr, 32'h1234_62B7);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_hi", bus.out_instr, 32'h1234_62B7);
    @(negedge clk);
    chk("bp_release_lo", bus.out_instr, 32'hFFF2_8293);
    step();
    repeat (2) step();

    // Reset while the ADDI half is pending.
    bus.out_ready = 1'b0;
    send(REQ_LI2);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("lilo_word", bus.out_instr, 32'hFFF2_8293);
    chk("lilo_req_ready", {31'd0, bus.req_ready}, 32'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      step();
    end
    send(REQ_I);
    @(negedge clk);
    chk("post_rst_I", bus.out_instr, 32'h0041_0193);
    step();

    // Odd branch offset: rejected with range check, truncated without.
    send(REQ_B13);
    @(negedge clk);
    chk("b13_err", {31'd0, bus.err}, {31'd0, RC});
    chk("b13_valid", {31'd0, bus.out_valid}, {31'd0, !RC});
    step();
    @(negedge clk);
    chk("b13_err_gone", {31'd0, bus.err}, 32'd0);
    step();

    repeat (4) step();
    @(negedge clk);
    chk("drain", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
